// File: rtl/eval_scheduler.sv
// Keyboard-to-token-buffer sequencer: forwards edits in idle, streams ds tokens to the evaluator on eval.
// Optional one-entry pending-edit replay during a scan is enabled by defining EVAL_EDIT_QUEUE_EN.
//
//   state | meaning
//   IDLE  | forward keyboard edits to ds, wait for eval
//   SCAN  | own the ds read port, stream tokens idx = 0..len-1
//   DONE  | one-cycle end-of-scan pulse, replay any pending edit
module eval_scheduler #(
   parameter int depth = 20,
   parameter int width = 8,
   localparam int AW = $clog2(depth),
   localparam int CW = $clog2(depth + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [width-1:0] kb_dataIn,
   input  logic             kb_insert,
   input  logic             kb_del,
   input  logic             kb_ptrLeft,
   input  logic             kb_ptrRight,
   input  logic             kb_eval,
   output logic [width-1:0] ds_dataIn,
   output logic             ds_insert,
   output logic             ds_del,
   output logic             ds_ptrLeft,
   output logic             ds_ptrRight,
   input  logic [CW-1:0]    ds_count,
   output logic [AW-1:0]    rd_addr,
   input  logic [width-1:0] rd_data,
   output logic             tok_valid,
   output logic [width-1:0] tok_data,
   output logic             tok_last,
   input  logic             tok_ready,
   output logic             eval_busy,
   output logic             eval_done,
   output logic             drop_flag
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   typedef enum logic [1:0] {OP_INS, OP_DEL, OP_LEFT, OP_RIGHT} op_t;

   state_t state, next_state;
   op_t win_op, issue_op;
   logic issue, drop, start;
   logic [width-1:0] issue_data;
   logic edit_any, edit_multi, all_multi;
   logic [2:0] n_edit, n_all;
   logic [AW-1:0] idx;
   logic [CW-1:0] len;
   logic loaded, load_ok, idx_last, hs_last;

`ifdef EVAL_EDIT_QUEUE_EN
   logic capture;
   logic pend_valid;
   op_t pend_op;
   logic [width-1:0] pend_data;
`endif

   assign n_edit = {2'b0, kb_insert} + {2'b0, kb_del} + {2'b0, kb_ptrLeft} + {2'b0, kb_ptrRight};
   assign n_all = n_edit + {2'b0, kb_eval};
   assign edit_any = (n_edit != 3'd0);
   assign edit_multi = (n_edit > 3'd1);
   assign all_multi = (n_all > 3'd1);

   assign load_ok = !tok_valid || tok_ready;
   assign idx_last = (CW'(idx) == len - CW'(1));
   assign hs_last = tok_valid && tok_ready && tok_last;

   assign eval_busy = (state != IDLE);
   assign eval_done = (state == DONE);
   assign rd_addr = (state == SCAN) ? idx : '0;

   always_comb begin
      win_op = OP_RIGHT;
      if (kb_insert)
         win_op = OP_INS;
      else if (kb_del)
         win_op = OP_DEL;
      else if (kb_ptrLeft)
         win_op = OP_LEFT;
   end

   always_comb begin
      next_state = state;
      issue = 1'b0;
      issue_op = win_op;
      issue_data = kb_dataIn;
      start = 1'b0;
      drop = 1'b0;
`ifdef EVAL_EDIT_QUEUE_EN
      capture = 1'b0;
`endif
      case (state)
         IDLE: begin
            drop = all_multi;
            if (kb_eval) begin
               start = 1'b1;
               next_state = (ds_count == '0) ? DONE : SCAN;
            end else begin
               issue = edit_any;
            end
         end
         SCAN: if (hs_last) next_state = DONE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (state != IDLE) begin
         drop = kb_eval;
`ifdef EVAL_EDIT_QUEUE_EN
         if (edit_any) begin
            drop = drop | edit_multi;
            if (pend_valid)
               drop = 1'b1;
            else if (state == SCAN)
               capture = 1'b1;
            else
               issue = 1'b1;
         end
         // In DONE a held edit goes out ahead of anything new from the keyboard.
         if (state == DONE && pend_valid) begin
            issue = 1'b1;
            issue_op = pend_op;
            issue_data = pend_data;
         end
`else
         drop = drop | edit_any;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ds_insert   <= 1'b0;
         ds_del      <= 1'b0;
         ds_ptrLeft  <= 1'b0;
         ds_ptrRight <= 1'b0;
         ds_dataIn   <= '0;
         tok_valid   <= 1'b0;
         tok_data    <= '0;
         tok_last    <= 1'b0;
         drop_flag   <= 1'b0;
         idx         <= '0;
         len         <= '0;
         loaded      <= 1'b0;
      end else begin
         ds_insert   <= issue && (issue_op == OP_INS);
         ds_del      <= issue && (issue_op == OP_DEL);
         ds_ptrLeft  <= issue && (issue_op == OP_LEFT);
         ds_ptrRight <= issue && (issue_op == OP_RIGHT);
         ds_dataIn   <= issue ? issue_data : '0;
         drop_flag   <= drop_flag | drop;
         if (start) begin
            len    <= ds_count;
            idx    <= '0;
            loaded <= 1'b0;
         end else if (state == SCAN && load_ok) begin
            // idx parks on len-1; 'loaded' records that the final token is in the register.
            if (!loaded) begin
               tok_valid <= 1'b1;
               tok_data  <= rd_data;
               tok_last  <= idx_last;
               if (idx_last)
                  loaded <= 1'b1;
               else
                  idx <= idx + AW'(1);
            end else begin
               tok_valid <= 1'b0;
               tok_last  <= 1'b0;
            end
         end
      end
   end

`ifdef EVAL_EDIT_QUEUE_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         pend_valid <= 1'b0;
         pend_op    <= OP_INS;
         pend_data  <= '0;
      end else if (capture) begin
         pend_valid <= 1'b1;
         pend_op    <= win_op;
         pend_data  <= kb_dataIn;
      end else if (state == DONE) begin
         pend_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_eval_scheduler.sv
// Directed bench for eval_scheduler: cycle vector table plus hand-written pending-edit and reset-mid-scan sequences.
module tb_eval_scheduler;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] kb_dataIn;
   logic       kb_insert, kb_del, kb_ptrLeft, kb_ptrRight, kb_eval;
   logic [7:0] ds_dataIn;
   logic       ds_insert, ds_del, ds_ptrLeft, ds_ptrRight;
   logic [4:0] ds_count;
   logic [4:0] rd_addr;
   logic [7:0] rd_data;
   logic       tok_valid, tok_last, tok_ready;
   logic [7:0] tok_data;
   logic       eval_busy, eval_done, drop_flag;

   logic [7:0] mem [0:19];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;
   assign rd_data = mem[rd_addr];

   eval_scheduler #(.depth(20), .width(8)) dut (
      .clock(clock), .reset(reset),
      .kb_dataIn(kb_dataIn), .kb_insert(kb_insert), .kb_del(kb_del),
      .kb_ptrLeft(kb_ptrLeft), .kb_ptrRight(kb_ptrRight), .kb_eval(kb_eval),
      .ds_dataIn(ds_dataIn), .ds_insert(ds_insert), .ds_del(ds_del),
      .ds_ptrLeft(ds_ptrLeft), .ds_ptrRight(ds_ptrRight), .ds_count(ds_count),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .tok_valid(tok_valid), .tok_data(tok_data), .tok_last(tok_last), .tok_ready(tok_ready),
      .eval_busy(eval_busy), .eval_done(eval_done), .drop_flag(drop_flag)
   );

   // kb field: {eval, insert, del, ptrLeft, ptrRight}
   localparam logic [4:0] K0 = 5'b00000, KE = 5'b10000, KI = 5'b01000, KD = 5'b00100, KL = 5'b00010;

   typedef struct {
      logic rst;
      logic [4:0] kb;
      logic [7:0] din;
      logic [4:0] cnt;
      logic rdy;
      logic chk;
      logic [24:0] exp;
   } vec_t;
   vec_t vecs[$];

   wire [24:0] outv = {ds_insert, ds_del, ds_ptrLeft, ds_ptrRight, ds_dataIn,
                       tok_valid, tok_data, tok_last, eval_busy, eval_done, drop_flag};

   function automatic logic [24:0] ex(input logic [3:0] ds, input logic [7:0] dd, input logic tv,
                                      input logic [7:0] td, input logic tl, input logic b,
                                      input logic dn, input logic dr);
      return {ds, dd, tv, td, tl, b, dn, dr};
   endfunction

   task automatic add(input logic r, input logic [4:0] k, input logic [7:0] d, input logic [4:0] c,
                      input logic rd, input logic ck, input logic [24:0] e);
      vec_t v;
      v.rst = r; v.kb = k; v.din = d; v.cnt = c; v.rdy = rd; v.chk = ck; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic step(input logic r, input logic [4:0] k, input logic [7:0] d, input logic [4:0] c,
                       input logic rd);
      @(negedge clock);
      reset = r;
      {kb_eval, kb_insert, kb_del, kb_ptrLeft, kb_ptrRight} = k;
      kb_dataIn = d;
      ds_count = c;
      tok_ready = rd;
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      int hs, done_k, del_k, bad, dn, pulses;
      int exp_del_k;
      for (int i = 0; i < 20; i++) mem[i] = 8'h00;
      mem[0] = 8'h31; mem[1] = 8'h2B; mem[2] = 8'h32;
      reset = 1'b1; kb_dataIn = '0; ds_count = '0; tok_ready = 1'b0;
      {kb_eval, kb_insert, kb_del, kb_ptrLeft, kb_ptrRight} = K0;

      // ---- vector table: row n is cycle n; expected outputs are those visible in that cycle
      add(1, K0, 8'h00, 0, 0, 0, ex(0, 0, 0, 8'h00, 0, 0, 0, 0));
      add(0, KI, 8'h31, 0, 0, 1, ex(0, 0, 0, 8'h00, 0, 0, 0, 0));        // reset state; insert 0x31
      add(0, K0, 8'h00, 0, 0, 1, ex(4'b1000, 8'h31, 0, 8'h00, 0, 0, 0, 0));
      add(0, KE, 8'h00, 3, 1, 1, ex(0, 0, 0, 8'h00, 0, 0, 0, 0));        // eval t=3
      add(0, K0, 8'h00, 3, 1, 1, ex(0, 0, 0, 8'h00, 0, 1, 0, 0));
      add(0, K0, 8'h00, 3, 1, 1, ex(0, 0, 1, 8'h31, 0, 1, 0, 0));
      add(0, K0, 8'h00, 3, 1, 1, ex(0, 0, 1, 8'h2B, 0, 1, 0, 0));
      add(0, K0, 8'h00, 3, 1, 1, ex(0, 0, 1, 8'h32, 1, 1, 0, 0));
      add(0, K0, 8'h00, 3, 1, 1, ex(0, 0, 0, 8'h32, 0, 1, 1, 0));        // eval_done t+5
      add(0, KE, 8'h00, 3, 1, 1, ex(0, 0, 0, 8'h32, 0, 0, 0, 0));        // eval t=9, backpressure
      add(0, K0, 8'h00, 3, 1, 1, ex(0, 0, 0, 8'h32, 0, 1, 0, 0));
      add(0, K0, 8'h00, 1, 1, 1, ex(0, 0, 1, 8'h31, 0, 1, 0, 0));        // ds_count change ignored
      add(0, K0, 8'h00, 1, 0, 1, ex(0, 0, 1, 8'h2B, 0, 1, 0, 0));
      add(0, K0, 8'h00, 1, 0, 1, ex(0, 0, 1, 8'h2B, 0, 1, 0, 0));
      add(0, K0, 8'h00, 1, 1, 1, ex(0, 0, 1, 8'h2B, 0, 1, 0, 0));
      add(0, K0, 8'h00, 1, 1, 1, ex(0, 0, 1, 8'h32, 1, 1, 0, 0));
      add(0, K0, 8'h00, 1, 1, 1, ex(0, 0, 0, 8'h32, 0, 1, 1, 0));        // eval_done t+7
      add(0, KE, 8'h00, 0, 1, 1, ex(0, 0, 0, 8'h32, 0, 0, 0, 0));        // empty eval t=17
      add(0, K0, 8'h00, 0, 1, 1, ex(0, 0, 0, 8'h32, 0, 1, 1, 0));
      add(0, KI | KD, 8'h41, 0, 1, 1, ex(0, 0, 0, 8'h32, 0, 0, 0, 0));   // insert beats del
      add(0, KE | KI, 8'h42, 0, 1, 1, ex(4'b1000, 8'h41, 0, 8'h32, 0, 0, 0, 1));
      add(0, K0, 8'h00, 0, 1, 1, ex(0, 0, 0, 8'h32, 0, 1, 1, 1));        // eval beat insert
      add(0, K0, 8'h00, 0, 1, 1, ex(0, 0, 0, 8'h32, 0, 0, 0, 1));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].kb, vecs[i].din, vecs[i].cnt, vecs[i].rdy);
         if (vecs[i].chk) check($sformatf("vec%0d", i), 32'(outv), 32'(vecs[i].exp));
      end

      // ---- edits during a scan: del then ptrLeft
      step(1, K0, 8'h00, 3, 1);
      step(0, KE, 8'h00, 3, 1);
      hs = 0; done_k = -1; del_k = -1; bad = 0;
      for (int k = 1; k <= 10; k++) begin
         step(0, (k == 2) ? KD : ((k == 3) ? KL : K0), 8'h00, 3, 1);
         if (tok_valid && tok_ready) hs++;
         if (eval_done) done_k = k;
         if (ds_del) del_k = k;
         if (ds_insert || ds_ptrLeft || ds_ptrRight) bad++;
      end
`ifdef EVAL_EDIT_QUEUE_EN
      exp_del_k = 6;
`else
      exp_del_k = -1;
`endif
      check("busy_handshakes", 32'(hs), 32'd3);
      check("busy_done_cycle", 32'(done_k), 32'd5);
      check("busy_del_cycle", 32'(del_k), 32'(exp_del_k));
      check("busy_other_pulses", 32'(bad), 32'd0);
      check("busy_drop_flag", 32'(drop_flag), 32'd1);

      // ---- reset mid-scan with an edit pending
      step(1, K0, 8'h00, 3, 0);
      step(0, KE, 8'h00, 3, 0);
      step(0, K0, 8'h00, 3, 0);
      step(0, KI, 8'h55, 3, 0);
      check("rst_pre_valid", {23'd0, tok_valid, tok_data}, {23'd0, 1'b1, 8'h31});
      step(1, K0, 8'h00, 3, 0);
      step(0, K0, 8'h00, 3, 0);
      check("rst_outputs", 32'(outv), 32'd0);
      check("rst_rd_addr", 32'(rd_addr), 32'd0);
      dn = 0; pulses = 0;
      for (int k = 0; k < 6; k++) begin
         step(0, (k == 1) ? KE : K0, 8'h00, 0, 1);   // empty eval gives a DONE where a stale edit would replay
         if (k < 2 && eval_done) dn++;
         if (ds_insert || ds_del || ds_ptrLeft || ds_ptrRight) pulses++;
      end
      check("rst_no_done", 32'(dn), 32'd0);
      check("rst_pending_discarded", 32'(pulses), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
